ifmap_stream_node: RTL and testbench
====================================

Name: ifmap_stream_node

Overview:
Parametrised successor to the single-shot ifmap memory node. It buffers NUM_TS binary input-feature maps of DEPTH_I×DEPTH_I bits, loaded bit-by-bit from the testbench/loader. On command it streams one NoC packet per (row, timestep) into the mesh router port, with the header fields built for a MESH_X-wide XY mesh. Unlike the previous node it is clocked, honours backpressure, rejects bad writes, and can replay the stored maps any number of times without reloading.

Parameters:
DEPTH_I, 25, ifmap side length; one row of DEPTH_I bits per packet payload (DEPTH_I ≤ WIDTH_payload)
NUM_TS, 2, number of timesteps / stored maps (1..8)
MESH_X, 5, mesh columns
NODE, 11, this node's 0-based mesh index (col = NODE%MESH_X, row = NODE/MESH_X)
WIDTH_packet, 57, packet width
WIDTH_payload, 40, payload field width (bits [WIDTH_payload-1:0])
WIDTH_addr, 12, write address width (≥ clog2(DEPTH_I²))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&&wr_ready
wr_ts  in  3  target map, 0..NUM_TS-1
wr_addr  in  WIDTH_addr  linear bit address, row = addr/DEPTH_I, col = addr%DEPTH_I
wr_data  in  1  ifmap bit
load_done  in  1  single-cycle pulse: loading finished
start  in  1  single-cycle pulse: begin a stream pass
pkt_valid  out  1  packet valid toward router
pkt_ready  in  1  router accepts
pkt_data  out  WIDTH_packet  packet
busy  out  1  high in SEND
done  out  1  one-cycle pulse after the last packet of a pass is accepted
err_addr  out  1  sticky: a write had wr_ts≥NUM_TS or wr_addr≥DEPTH_I²; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert usage): state=LOAD. pkt_valid=0, pkt_data=0, busy=0, done=0, err_addr=0, wr_ready=1. Memory is not reset; its contents are retained across reset but are undefined until written.
- States: LOAD, READY, SEND.
  - LOAD: wr_ready=1; start is ignored; load_done → READY.
  - READY: wr_ready=1, so rewrites are allowed; start → SEND.
  - SEND: wr_ready=0; start and load_done are ignored; after the last packet is accepted → READY with done=1 for one cycle.
- Writes: an in-range write updates mem[wr_ts][row][col] in the accepting cycle; the last write wins. An out-of-range write is dropped and sets err_addr. A write and load_done in the same cycle: the write is performed, then the transition happens.
- Stream order: outer loop row i = 0..DEPTH_I-1, inner loop t = 0..NUM_TS-1. Each pass is DEPTH_I×NUM_TS packets.
- Latency: the start cycle in READY gives pkt_valid=1 with the first packet on the next edge. Each handshake presents the next packet on the following edge (1 packet/cycle when pkt_ready=1).
- pkt_data and pkt_valid stay stable while pkt_valid&&!pkt_ready. pkt_valid drops the cycle after the final handshake.
- Destination: dcol = min(i, MESH_X-1), drow = t, dest = drow*MESH_X + dcol. scol = NODE%MESH_X, srow = NODE/MESH_X.
- Packet fields (all other bits 0):
  - [56]=1
  - [55:52]=NODE+1
  - [51:48]=dest+1
  - [47] xdir = 1 if dcol>scol (right), else 0
  - [46:44] = |dcol-scol|
  - [43] ydir = 1 if drow>srow (down), else 0
  - [42:40] = |drow-srow|
  - [DEPTH_I-1:0] = mem[t][i], with bit c = column c
- Hop fields are 3 bits. Parameter combinations needing more than 7 hops are illegal; this is checked by an elaboration assertion.
- Reset mid-SEND aborts the pass immediately; no done pulse is produced.

Test Plan:
- Reset defaults: assert rst_n=0 mid-cycle → pkt_valid=0, busy=0, err_addr=0, wr_ready=1 asynchronously.
- Load and stream (defaults): write map0 with bit (r,c)=(r+c)&1 and map1 with its inverse, pulse load_done, pulse start, pkt_ready=1 → 50 packets, one per cycle, then one done pulse.
  - First packet header: [56:40] fields = 1, 0xC, 0x1, 0, 1, 0, 2. Payload 0x0AAAAAA.
  - Packet for i=7, t=1: dest field 0xA, xdir=1, xhop=3, ydir=0, yhop=1.
- Backpressure: toggle pkt_ready pseudo-randomly → the packet sequence is identical to the free-flowing run; pkt_data never changes while stalled.
- Bad writes: wr_ts=2 or wr_addr=625 → err_addr=1 and stays set; memory is unchanged (verified by a stream pass).
- Ignored and simultaneous events:
  - start in LOAD → no packets.
  - start during SEND → no effect.
  - Write + load_done in the same cycle → that write appears in the stream.
- Replay and abort:
  - Second start after done → the same 50 packets again.
  - rst_n low after packet 10 → pkt_valid=0, no done pulse; reload and restart gives a full, correct pass.

Source files
------------

// File: rtl/ifmap_stream_node.sv
// ifmap_stream_node: buffers NUM_TS binary ifmaps and streams one NoC packet
// per (row, timestep) toward the mesh router, honouring backpressure.
module ifmap_stream_node #(
    parameter int DEPTH_I       = 25,
    parameter int NUM_TS        = 2,
    parameter int MESH_X        = 5,
    parameter int NODE          = 11,
    parameter int WIDTH_packet  = 57,
    parameter int WIDTH_payload = 40,
    parameter int WIDTH_addr    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_ts,
    input  logic [WIDTH_addr-1:0]   wr_addr,
    input  logic                    wr_data,
    input  logic                    load_done,
    input  logic                    start,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [WIDTH_packet-1:0] pkt_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_addr
);

    localparam int RW       = (DEPTH_I > 1) ? $clog2(DEPTH_I) : 1;
    localparam int TW       = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam int SCOL     = NODE % MESH_X;
    localparam int SROW     = NODE / MESH_X;
    localparam int H        = WIDTH_payload;
    localparam int MAX_DCOL = (DEPTH_I < MESH_X) ? DEPTH_I - 1 : MESH_X - 1;
    localparam int XHOP_MAX = (SCOL > MAX_DCOL - SCOL) ? SCOL : MAX_DCOL - SCOL;
    localparam int YHOP_MAX = (SROW > NUM_TS - 1 - SROW) ? SROW : NUM_TS - 1 - SROW;
    localparam int DEST_MAX = (NUM_TS - 1) * MESH_X + MAX_DCOL;

    // Header fields are fixed-width: hops are 3 bits, node ids 4 bits (offset by one).
    if (XHOP_MAX > 7 || YHOP_MAX > 7) begin : g_bad_hops
        $error("ifmap_stream_node: parameters need more than 7 hops");
    end
    if (NODE + 1 > 15 || DEST_MAX + 1 > 15) begin : g_bad_ids
        $error("ifmap_stream_node: node id does not fit the 4-bit header field");
    end
    if (DEPTH_I > WIDTH_payload || WIDTH_packet != WIDTH_payload + 17 || NUM_TS < 1 || NUM_TS > 8) begin : g_bad_geom
        $error("ifmap_stream_node: inconsistent payload/packet geometry");
    end

    typedef enum logic [1:0] {LOAD, READY, SEND} state_t;

    state_t                  state, state_n;
    logic [RW-1:0]           row, row_n;
    logic [TW-1:0]           ts, ts_n;
    logic                    valid_n, done_n, err_n;
    logic [WIDTH_packet-1:0] data_n;
    logic [DEPTH_I-1:0]      mem [NUM_TS][DEPTH_I];

    logic                    wr_fire, in_range, last;
    logic [RW-1:0]           wr_row, wr_col, nrow;
    logic [TW-1:0]           wr_t, nts;

    assign wr_ready = (state != SEND);
    assign busy     = (state == SEND);
    assign wr_fire  = wr_valid && wr_ready;
    assign in_range = (32'(wr_ts) < NUM_TS) && (32'(wr_addr) < DEPTH_I * DEPTH_I);
    assign wr_row   = RW'(32'(wr_addr) / DEPTH_I);
    assign wr_col   = RW'(32'(wr_addr) % DEPTH_I);
    assign wr_t     = TW'(wr_ts);
    assign last     = (row == RW'(DEPTH_I - 1)) && (ts == TW'(NUM_TS - 1));
    assign nts      = (ts == TW'(NUM_TS - 1)) ? '0 : ts + TW'(1);
    assign nrow     = (ts == TW'(NUM_TS - 1)) ? row + RW'(1) : row;

    function automatic logic [WIDTH_packet-1:0] build_pkt(input int i, input int t,
                                                          input logic [DEPTH_I-1:0] bits);
        int                      dcol;
        int                      dest;
        logic [WIDTH_packet-1:0] p;
        dcol           = (i < MESH_X - 1) ? i : MESH_X - 1;
        dest           = t * MESH_X + dcol;
        p              = '0;
        p[H+16]        = 1'b1;
        p[H+15:H+12]   = 4'(NODE + 1);
        p[H+11:H+8]    = 4'(dest + 1);
        p[H+7]         = (dcol > SCOL);
        p[H+6:H+4]     = 3'((dcol > SCOL) ? dcol - SCOL : SCOL - dcol);
        p[H+3]         = (t > SROW);
        p[H+2:H]       = 3'((t > SROW) ? t - SROW : SROW - t);
        p[DEPTH_I-1:0] = bits;
        return p;
    endfunction

    // Map storage: not reset, written only by accepted in-range writes.
    always_ff @(posedge clk) begin
        if (wr_fire && in_range) begin
            mem[wr_t][wr_row][wr_col] <= wr_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            row       <= '0;
            ts        <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            done      <= 1'b0;
            err_addr  <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            ts        <= ts_n;
            pkt_valid <= valid_n;
            pkt_data  <= data_n;
            done      <= done_n;
            err_addr  <= err_n;
        end
    end

    // Next-state, stream sequencing and packet assembly.
    always_comb begin
        state_n = state;
        row_n   = row;
        ts_n    = ts;
        valid_n = pkt_valid;
        data_n  = pkt_data;
        done_n  = 1'b0;
        err_n   = err_addr || (wr_fire && !in_range);
        case (state)
            LOAD: begin
                if (load_done) state_n = READY;
            end
            READY: begin
                if (start) begin
                    state_n = SEND;
                    row_n   = '0;
                    ts_n    = '0;
                    valid_n = 1'b1;
                    data_n  = build_pkt(0, 0, mem[0][0]);
                end
            end
            SEND: begin
                if (pkt_valid && pkt_ready) begin
                    if (last) begin
                        state_n = READY;
                        valid_n = 1'b0;
                        data_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        row_n  = nrow;
                        ts_n   = nts;
                        data_n = build_pkt(int'(nrow), int'(nts), mem[nts][nrow]);
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

endmodule

// File: tb/tb_ifmap_stream_node.sv
module tb_ifmap_stream_node;

    localparam int DEPTH_I = 25;
    localparam int NUM_TS  = 2;
    localparam int MESH_X  = 5;
    localparam int NODE    = 11;
    localparam int TOTAL   = DEPTH_I * NUM_TS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_ts = '0;
    logic [11:0] wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        load_done = 1'b0;
    logic        start = 1'b0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [56:0] pkt_data;
    logic        busy;
    logic        done;
    logic        err_addr;

    int n_checks = 0;
    int n_errors = 0;

    bit          ref_mem [NUM_TS][DEPTH_I][DEPTH_I];
    logic [56:0] got_q[$];
    logic [56:0] first_q[$];

    ifmap_stream_node #(
        .DEPTH_I(DEPTH_I), .NUM_TS(NUM_TS), .MESH_X(MESH_X), .NODE(NODE),
        .WIDTH_packet(57), .WIDTH_payload(40), .WIDTH_addr(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ts(wr_ts), .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
        .start(start), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .busy(busy), .done(done), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packet from the stored maps, assembled field by field with shifts.
    function automatic logic [56:0] exp_pkt(input int i, input int t);
        int          scol, srow, dcol, dest;
        logic [56:0] p;
        scol = NODE % MESH_X;
        srow = NODE / MESH_X;
        dcol = (i < MESH_X - 1) ? i : MESH_X - 1;
        dest = t * MESH_X + dcol;
        p = 57'(1) << 56;
        p = p | (57'(NODE + 1) << 52);
        p = p | (57'(dest + 1) << 48);
        if (dcol > scol) p = p | (57'(1) << 47) | (57'(dcol - scol) << 44);
        else             p = p | (57'(scol - dcol) << 44);
        if (t > srow)    p = p | (57'(1) << 43) | (57'(t - srow) << 40);
        else             p = p | (57'(srow - t) << 40);
        for (int c = 0; c < DEPTH_I; c++) begin
            if (ref_mem[t][i][c]) p = p | (57'(1) << c);
        end
        return p;
    endfunction

    task automatic write_bit(input int t, input int addr, input bit d, input bit ld);
        wr_valid  = 1'b1;
        wr_ts     = 3'(t);
        wr_addr   = 12'(addr);
        wr_data   = d;
        load_done = ld;
        if (t < NUM_TS && addr < DEPTH_I * DEPTH_I)
            ref_mem[t][addr / DEPTH_I][addr % DEPTH_I] = d;
        tick();
        wr_valid  = 1'b0;
        load_done = 1'b0;
    endtask

    // mode 0: checkerboard / inverse; mode 1: random bits. The final write carries load_done.
    task automatic load_maps(input int mode, input bit last_bit);
        for (int t = 0; t < NUM_TS; t++) begin
            for (int a = 0; a < DEPTH_I * DEPTH_I; a++) begin
                bit b;
                if (mode == 0) b = bit'(((a / DEPTH_I) + (a % DEPTH_I) + t) & 1);
                else           b = bit'($urandom_range(0, 1));
                write_bit(t, a, b, 1'b0);
            end
        end
        write_bit(NUM_TS - 1, DEPTH_I * DEPTH_I - 1, last_bit, 1'b1);
        check("load_ready_wr", 64'(wr_ready), 64'(1));
        check("load_ready_busy", 64'(busy), 64'(0));
    endtask

    task automatic stream_pass(input bit rand_ready, input bit poke, input int abort_at);
        int          idx, cycles;
        bit          stalled;
        logic [56:0] held;
        got_q.delete();
        idx = 0; cycles = 0; stalled = 1'b0; held = '0;
        pkt_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_valid", 64'(pkt_valid), 64'(1));
        check("start_busy", 64'(busy), 64'(1));
        while (idx < TOTAL && cycles < 4000) begin
            if (idx == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(pkt_valid), 64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_wr_ready", 64'(wr_ready), 64'(1));
                check("abort_err", 64'(err_addr), 64'(0));
                check("abort_data", 64'(pkt_data), 64'(0));
                pkt_ready = 1'b1;
                tick(); tick();
                rst_n = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    check("abort_no_done", 64'(done), 64'(0));
                    check("abort_idle", 64'(pkt_valid), 64'(0));
                end
                return;
            end
            if (stalled) begin
                check("stall_hold", 64'(pkt_data), 64'(held));
                check("stall_valid", 64'(pkt_valid), 64'(1));
            end
            if (!pkt_valid) begin
                check("valid_gap", 64'(pkt_valid), 64'(1));
                break;
            end
            pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (cycles == 7);
            load_done = poke && (cycles == 9);
            if (pkt_ready) begin
                check("pkt", 64'(pkt_data), 64'(exp_pkt(idx / NUM_TS, idx % NUM_TS)));
                got_q.push_back(pkt_data);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = pkt_data;
            end
            tick();
            cycles++;
            start     = 1'b0;
            load_done = 1'b0;
        end
        check("pass_count", 64'(idx), 64'(TOTAL));
        if (!rand_ready) check("throughput", 64'(cycles), 64'(TOTAL));
        check("done_pulse", 64'(done), 64'(1));
        check("end_valid", 64'(pkt_valid), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
        pkt_ready = 1'b0;
        tick();
        check("done_width", 64'(done), 64'(0));
        check("idle_valid", 64'(pkt_valid), 64'(0));
    endtask

    initial begin
        logic [56:0] p;
        logic [16:0] hdr;
        logic [24:0] pay;

        tick();
        check("rst_valid", 64'(pkt_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err_addr), 64'(0));
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        check("rst_data", 64'(pkt_data), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // start while still loading must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("load_start_valid", 64'(pkt_valid), 64'(0));
            check("load_start_busy", 64'(busy), 64'(0));
            tick();
        end

        // final write (map1, last bit) lands together with load_done; inverse pattern would give 1
        load_maps(0, 1'b0);

        stream_pass(1'b0, 1'b0, -1);
        first_q = got_q;
        check("first_q_size", 64'(first_q.size()), 64'(TOTAL));
        if (first_q.size() == TOTAL) begin
            p = first_q[0];
            hdr = p[56:40];
            pay = p[24:0];
            check("hdr_first", 64'(hdr), 64'({1'b1, 4'hC, 4'h1, 1'b0, 3'd1, 1'b0, 3'd2}));
            check("payload_first", 64'(pay), 64'(25'h0AAAAAA));
            p = first_q[15];
            hdr = p[56:40];
            check("hdr_i7_t1", 64'(hdr), 64'({1'b1, 4'hC, 4'hA, 1'b1, 3'd3, 1'b0, 3'd1}));
            p = first_q[TOTAL-1];
            check("simul_write_bit", 64'(p[24]), 64'(0));
        end

        // backpressure, plus start/load_done pulses mid-stream that must be ignored
        stream_pass(1'b1, 1'b1, -1);
        check("bp_size", 64'(got_q.size()), 64'(TOTAL));
        if (got_q.size() == TOTAL && first_q.size() == TOTAL) begin
            for (int k = 0; k < TOTAL; k++) check("bp_replay", 64'(got_q[k]), 64'(first_q[k]));
        end

        // out-of-range writes: dropped, sticky error
        write_bit(2, 0, ~ref_mem[0][0][0], 1'b0);
        check("err_ts", 64'(err_addr), 64'(1));
        write_bit(0, 625, 1'b1, 1'b0);
        write_bit(7, 30, ~ref_mem[1][1][5], 1'b0);
        check("err_addr_sticky", 64'(err_addr), 64'(1));
        for (int k = 0; k < 20; k++) begin
            write_bit(int'($urandom_range(0, NUM_TS - 1)), int'($urandom_range(0, DEPTH_I * DEPTH_I - 1)),
                      bit'($urandom_range(0, 1)), 1'b0);
        end
        check("err_after_good", 64'(err_addr), 64'(1));
        stream_pass(1'b1, 1'b0, -1);
        check("err_after_pass", 64'(err_addr), 64'(1));

        // abort after 10 packets, then reload and run a full pass
        stream_pass(1'b1, 1'b0, 10);
        load_maps(1, bit'($urandom_range(0, 1)));
        stream_pass(1'b1, 1'b0, -1);
        stream_pass(1'b0, 1'b0, -1);
        check("final_err", 64'(err_addr), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
